// File: rtl/tuple_pkg.sv
// ---------------------------------------------------------------------------
// tuple_pkg
// Shared definitions for the nibble-tuple packer/unpacker pair: data widths,
// bit offsets of the unpacker's packed output bus, the nibble-tuple type and
// the byte-to-tuple split used by the unpacker.
// ---------------------------------------------------------------------------
package tuple_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    // Field offsets inside the packed unpacker output bus
    localparam int OUT_READY_BIT = 9;
    localparam int OUT_VALID_BIT = 8;
    localparam int FIRST_HI      = 7;
    localparam int FIRST_LO      = 4;
    localparam int SECOND_HI     = 3;
    localparam int SECOND_LO     = 0;

    typedef struct packed {
        logic [NIBBLE_W-1:0] first;
        logic [NIBBLE_W-1:0] second;
    } nibble_tuple_t;

    // The high nibble always becomes the first tuple element, so that packing
    // and unpacking are exact inverses of each other.
    function automatic nibble_tuple_t split_byte(input logic [BYTE_W-1:0] b);
        nibble_tuple_t t;
        t.first  = b[BYTE_W-1:NIBBLE_W];
        t.second = b[NIBBLE_W-1:0];
        return t;
    endfunction

endpackage

// File: rtl/unpack_stage.sv
// ---------------------------------------------------------------------------
// unpack_stage
// One valid+data slot of the unpack pipeline, with its combinational ready.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   prev_valid  : valid of the upstream slot (or the producer)
//   prev_data   : data of the upstream slot (or the producer)
//   next_ready  : ready of the downstream slot (or the consumer)
//   valid, data : contents of this slot
//   ready       : this slot can load this cycle (empty, or downstream moves)
// ---------------------------------------------------------------------------
module unpack_stage
    import tuple_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    input  logic [BYTE_W-1:0] prev_data,
    input  logic              next_ready,
    output logic              valid,
    output logic [BYTE_W-1:0] data,
    output logic              ready
);

    // An empty slot is always ready; a full one only if it can drain.
    assign ready = !valid || next_ready;

    // Bubbles load zero data so that an idle output bus never shows stale
    // or never-accepted bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            data  <= prev_valid ? prev_data : '0;
        end
    end

endmodule

// File: rtl/tuple_unpack_pipeline.sv
// ---------------------------------------------------------------------------
// tuple_unpack_pipeline
// Accepts bytes with valid/ready flow control and emits them as nibble tuples
// (byte[7:4], byte[3:0]) after DEPTH elastic register stages.
// Ports:
//   _i_clk, _i_rst : clock and asynchronous active-high reset
//   _i_in_val      : byte to unpack
//   _i_in_valid    : producer has a byte on _i_in_val
//   _i_out_ready   : consumer can take the tuple this cycle
//   __output       : {in_ready, out_valid, first nibble, second nibble}
// ---------------------------------------------------------------------------
module tuple_unpack_pipeline
    import tuple_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic              _i_clk,
    input  logic              _i_rst,
    input  logic [BYTE_W-1:0] _i_in_val,
    input  logic              _i_in_valid,
    input  logic              _i_out_ready,
    output logic [9:0]        __output
);

    // Index 0 of the valid/data chains is the producer; index DEPTH+1 of the
    // ready chain is the consumer.
    logic              valid_chain [0:DEPTH];
    logic [BYTE_W-1:0] data_chain  [0:DEPTH];
    logic              ready_chain [1:DEPTH+1];
    nibble_tuple_t     out_tuple;

    assign valid_chain[0]       = _i_in_valid;
    assign data_chain[0]        = _i_in_val;
    assign ready_chain[DEPTH+1] = _i_out_ready;

    // Ready ripples combinationally from the consumer to the producer, so a
    // full pipeline can pop and push on the same edge.
    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        unpack_stage u_stage (
            .clk        (_i_clk),
            .rst        (_i_rst),
            .prev_valid (valid_chain[k-1]),
            .prev_data  (data_chain[k-1]),
            .next_ready (ready_chain[k+1]),
            .valid      (valid_chain[k]),
            .data       (data_chain[k]),
            .ready      (ready_chain[k])
        );
    end

    assign out_tuple = split_byte(data_chain[DEPTH]);

    assign __output[OUT_READY_BIT]       = ready_chain[1];
    assign __output[OUT_VALID_BIT]       = valid_chain[DEPTH];
    assign __output[FIRST_HI:FIRST_LO]   = out_tuple.first;
    assign __output[SECOND_HI:SECOND_LO] = out_tuple.second;

endmodule

// File: tb/tb_tuple_unpack_pipeline.sv
// ---------------------------------------------------------------------------
// tb_tuple_unpack_pipeline
// Scoreboard bench for tuple_unpack_pipeline: the driver pushes the expected
// tuple of every accepted byte, a negedge monitor pops and compares whatever
// the DUT hands to the consumer, and directed checks cover latency, reset and
// the full-pipeline corner cases.
// ---------------------------------------------------------------------------
module tb_tuple_unpack_pipeline;
    import tuple_pkg::*;

    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_val;
    logic       in_valid;
    logic       out_ready;
    logic [9:0] dut_out;

    int errors = 0;
    int checks = 0;

    nibble_tuple_t exp_q[$];
    bit            mon_en   = 1'b0;
    bit            rand_run = 1'b0;
    bit            acc;

    always #5 clk = ~clk;

    tuple_unpack_pipeline #(.DEPTH(DEPTH)) dut (
        ._i_clk       (clk),
        ._i_rst       (rst),
        ._i_in_val    (in_val),
        ._i_in_valid  (in_valid),
        ._i_out_ready (out_ready),
        .__output     (dut_out)
    );

    // Reference mapping: high nibble first, low nibble second
    function automatic nibble_tuple_t model_tuple(input logic [7:0] b);
        nibble_tuple_t t;
        t.first  = 4'(b / 16);
        t.second = 4'(b % 16);
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of input starting just after a rising edge; an accepted
    // byte is recorded in the scoreboard at the edge that captures it.
    task automatic applyStimulus(input logic [7:0] b, input bit v, output bit accepted);
        in_val   = b;
        in_valid = v;
        @(negedge clk);
        accepted = v && dut_out[OUT_READY_BIT];
        @(posedge clk);
        if (accepted) exp_q.push_back(model_tuple(b));
        #1;
    endtask

    // Offer a byte and hold it stable until the DUT takes it
    task automatic sendByte(input logic [7:0] b);
        bit a;
        a = 1'b0;
        for (int n = 0; n < 100 && !a; n++) applyStimulus(b, 1'b1, a);
        if (!a) checkOutput("send_timeout", 32'(a), 32'd1);
    endtask

    // Monitor: in_ready follows from occupancy, and every presented tuple must
    // be the oldest outstanding byte; it is consumed only when out_ready is set.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            checkOutput("in_ready", 32'(dut_out[OUT_READY_BIT]),
                        32'((exp_q.size() < DEPTH) || out_ready));
            if (dut_out[OUT_VALID_BIT]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output",
                             dut_out[7:0]);
                end else begin
                    checkOutput("first_nibble", 32'(dut_out[FIRST_HI:FIRST_LO]),
                                32'(exp_q[0].first));
                    checkOutput("second_nibble", 32'(dut_out[SECOND_HI:SECOND_LO]),
                                32'(exp_q[0].second));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] stream [4];
        stream = '{8'h00, 8'hFF, 8'h5C, 8'hC5};

        rst       = 1'b1;
        in_val    = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_out", 32'(dut_out[8:0]), 32'h000);
        checkOutput("reset_in_ready", 32'(dut_out[OUT_READY_BIT]), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic latency: visible after the third edge counting the capture
        $display("[TB] basic latency");
        applyStimulus(8'h1A, 1'b1, acc);
        in_valid = 1'b0;
        checkOutput("basic_accept", 32'(acc), 32'd1);
        @(posedge clk); #1;
        checkOutput("latency_early", 32'(dut_out[OUT_VALID_BIT]), 32'd0);
        @(posedge clk); #1;
        checkOutput("latency_basic", 32'(dut_out[8:0]), 32'h11A);
        @(posedge clk); #1;
        checkOutput("latency_after", 32'(dut_out[OUT_VALID_BIT]), 32'd0);

        // Back-to-back streaming
        $display("[TB] streaming");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(stream[i], 1'b1, acc);
            checkOutput("stream_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("stream_third", 32'(dut_out[8:0]), 32'h15C);
        @(posedge clk); #1;
        checkOutput("stream_fourth", 32'(dut_out[8:0]), 32'h1C5);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure fill, then simultaneous pop and push on a full pipe
        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'h11, 1'b1, acc); checkOutput("fill_accept_11", 32'(acc), 32'd1);
        applyStimulus(8'h22, 1'b1, acc); checkOutput("fill_accept_22", 32'(acc), 32'd1);
        applyStimulus(8'h33, 1'b1, acc); checkOutput("fill_accept_33", 32'(acc), 32'd1);
        applyStimulus(8'h44, 1'b1, acc); checkOutput("fill_full_44", 32'(acc), 32'd0);
        applyStimulus(8'h44, 1'b1, acc); checkOutput("fill_hold_44", 32'(acc), 32'd0);
        checkOutput("stall_out", 32'(dut_out[8:0]), 32'h111);
        out_ready = 1'b1;
        applyStimulus(8'h44, 1'b1, acc); checkOutput("push_pop_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        checkOutput("gapless_22", 32'(dut_out[8:0]), 32'h122);
        @(posedge clk); #1;
        checkOutput("gapless_33", 32'(dut_out[8:0]), 32'h133);
        @(posedge clk); #1;
        checkOutput("gapless_44", 32'(dut_out[8:0]), 32'h144);
        @(posedge clk); #1;
        checkOutput("drained_valid", 32'(dut_out[OUT_VALID_BIT]), 32'd0);

        // Asynchronous reset with bytes in flight
        $display("[TB] reset mid-flight");
        applyStimulus(8'hA1, 1'b1, acc);
        applyStimulus(8'hB2, 1'b1, acc);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(dut_out[OUT_VALID_BIT]), 32'd0);
        checkOutput("midrst_ready", 32'(dut_out[OUT_READY_BIT]), 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(8'h9E, 1'b1, acc);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("postrst_early", 32'(dut_out[OUT_VALID_BIT]), 32'd0);
        @(posedge clk); #1;
        checkOutput("postrst_out", 32'(dut_out[8:0]), 32'h19E);
        @(posedge clk); #1;

        // Data without valid is never captured
        $display("[TB] invalid input");
        in_val   = 8'h77;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("invalid_ignored", 32'(dut_out[8:0]), 32'h000);
        end

        // Random traffic with random consumer backpressure
        $display("[TB] random traffic");
        rand_run = 1'b1;
        fork
            while (rand_run) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 2) != 0);
            end
        join_none
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(8'($urandom), 1'b0, acc);
            else                           sendByte(8'($urandom));
        end
        in_valid = 1'b0;
        rand_run = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (DEPTH + 4) @(posedge clk);
        #1;
        checkOutput("random_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tuple_unpack_pipeline.md
Name: tuple_unpack_pipeline

Overview:
- Inverse of the nibble-tuple packing pipeline: accepts a byte and emits it as a tuple (first nibble, second nibble) after a fixed-depth register pipeline.
- Adds valid/ready flow control so it can sit between a byte producer and a backpressuring tuple consumer.
- All outputs are packed into one output bus, per the Spade single-output convention.

Parameters:
- DEPTH, 3, number of register stages; legal range 1..8.

Ports:
- _i_clk  input  1  clock; all state updates on the rising edge.
- _i_rst  input  1  asynchronous, active-high reset.
- _i_in_val  input  8  byte to unpack.
- _i_in_valid  input  1  producer asserts when _i_in_val holds a byte.
- _i_out_ready  input  1  consumer can take the tuple on __output this cycle.
- __output  output  10  packed result:
  - [9] in_ready, combinational.
  - [8] out_valid.
  - [7:4] first nibble, equal to byte[7:4].
  - [3:0] second nibble, equal to byte[3:0].

Behaviour:
- Reset (async, active-high):
  - all stage valid bits clear to 0 immediately; stage data clears to 0.
  - __output[8:0] = 0 while _i_rst is high and until the first accepted byte reaches the last stage.
  - __output[9] = 1 one delta after reset asserts, because all stages are empty.
- Stage k (1..DEPTH) holds valid_k and data_k[7:0].
- Ready chain:
  - rdy_{DEPTH+1} = _i_out_ready.
  - rdy_k = !valid_k | rdy_{k+1}.
  - in_ready = rdy_1.
- At each rising edge, when rdy_k is set, stage k loads from stage k-1. Stage 1 loads from the inputs. Otherwise stage k holds.
- Input handshake: a byte is accepted at an edge iff _i_in_valid & in_ready. If _i_in_valid is set but not accepted, the producer must hold the byte stable. Data with _i_in_valid = 0 is never captured as valid.
- Output handshake: a tuple transfers at an edge iff out_valid & _i_out_ready. When out_valid is set and _i_out_ready is clear, __output[8:0] holds stable.
- Latency: with _i_out_ready held at 1, a byte accepted at edge n is on __output from just after edge n+DEPTH-1. With the default, the output appears after the 3rd edge, counting the capture edge.
- Throughput: 1 byte per cycle while _i_out_ready = 1.
- Full pipeline (all valid) with _i_out_ready = 0: in_ready = 0, nothing moves, no data is lost.
- Simultaneous output pop and input push on a full pipeline: both succeed in the same edge, because ready propagates combinationally.
- Bubbles (valid = 0 stages) collapse when downstream is stalled. A stalled pipeline absorbs up to DEPTH bytes.
- Ordering is strictly FIFO. No reordering, duplication or drop.
- Reset mid-operation discards all in-flight bytes. The first post-reset output is the first byte accepted after reset deasserts.
- Field mapping is fixed: byte[7:4] goes to the first nibble, byte[3:0] to the second. This is the exact inverse of the packer.
- No arithmetic. Widths are exact, with no truncation or extension.

Decomposition:
- Shared package tuple_pkg:
  - NIBBLE_W = 4, BYTE_W = 8.
  - output field offsets OUT_READY_BIT = 9, OUT_VALID_BIT = 8, FIRST_HI = 7, FIRST_LO = 4, SECOND_HI = 3, SECOND_LO = 0.
  - nibble-tuple typedef, reused by the packer.
- One sub-module, unpack_stage: one valid+data slot with its ready equation, instantiated DEPTH times in a generate chain.

Test Plan:
- Basic latency: reset 2 cycles, send 0x1A with valid=1 for one cycle, out_ready=1.
  - After the 3rd edge, __output[8:0] = {1, 0x1, 0xA}.
  - One cycle later, out_valid = 0.
- Streaming: bytes 0x00, 0xFF, 0x5C, 0xC5 on consecutive cycles, out_ready=1.
  - Tuples (0,0), (F,F), (5,C), (C,5) appear on consecutive cycles starting at latency 3.
  - in_ready stays 1 throughout.
- Backpressure fill: out_ready=0, offer 0x11, 0x22, 0x33, 0x44.
  - First three are accepted; in_ready = 0 while 0x44 is offered.
  - Raise out_ready: outputs (1,1), (2,2), (3,3), (4,4) in order, no gaps after the first.
- Simultaneous push/pop on a full pipeline: full with 0x11..0x33, out_ready=1, push 0x44 the same cycle.
  - 0x11 leaves and 0x44 is accepted in the same edge.
  - Output sequence continues (2,2), (3,3), (4,4).
- Reset mid-flight: two bytes in flight, pulse _i_rst asynchronously between edges.
  - out_valid drops to 0 immediately and in_ready = 1.
  - Then send 0x9E: the only output seen is (9,E), at latency 3.
- Invalid input ignored: _i_in_val = 0x77 with _i_in_valid = 0 for 5 cycles → out_valid stays 0.
